// File: rtl/text_cell_reader.sv
// Reads one text row of character/attribute byte pairs from the text RAM per
// active scanline and streams them to the glyph renderer through a 2-entry FIFO.
module text_cell_reader #(
  parameter int VIS_COLS = 30,
  parameter int VIS_ROWS = 17,
  parameter int CELL_H   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        line_start,
  output logic        ram_ce,
  output logic [10:0] ram_ad,
  input  logic [7:0]  ram_dout,
  output logic        cell_valid,
  input  logic        cell_ready,
  output logic [7:0]  cell_char,
  output logic [7:0]  cell_attr,
  output logic [4:0]  cell_col,
  output logic [3:0]  cell_line,
  output logic        cell_last,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, RD_CHAR, RD_ATTR, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] attr;
    logic [4:0] col;
    logic [3:0] line;
    logic       last;
  } cell_t;

  localparam logic [4:0] LAST_COL  = 5'(VIS_COLS - 1);
  localparam logic [3:0] LAST_SCAN = 4'(CELL_H - 1);
  localparam logic [5:0] ROW_LIMIT = 6'(VIS_ROWS);

  state_t      state;
  logic [5:0]  text_row, row_base, row_next;
  logic [3:0]  scan, scan_base, scan_next;
  logic [4:0]  col, next_col;

  // Cell whose char is captured and whose attr arrives on ram_dout next cycle.
  logic        pend;
  logic [7:0]  pend_ch;
  logic [4:0]  pend_col;
  logic [3:0]  pend_line;
  logic        pend_last;

  cell_t       fifo [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;

  logic        pop, push, flush, restart, advance, start, slot_free;
  logic [2:0]  occupancy;

  assign cell_valid = (count != 2'd0);
  assign cell_char  = fifo[rd_ptr].ch;
  assign cell_attr  = fifo[rd_ptr].attr;
  assign cell_col   = fifo[rd_ptr].col;
  assign cell_line  = fifo[rd_ptr].line;
  assign cell_last  = fifo[rd_ptr].last;
  assign busy       = (state != IDLE) || (count != 2'd0);
  assign pop        = cell_valid && cell_ready;
  assign next_col   = col + 5'd1;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    row_base  = frame_start ? 6'd0 : text_row;
    scan_base = frame_start ? 4'd0 : scan;
    row_next  = row_base;
    scan_next = scan_base;
    restart   = line_start && !frame_start && busy && (text_row < ROW_LIMIT);
    // A line aborted mid-fetch still counts as a finished line.
    advance   = !frame_start && ((state == DRAIN) || (restart && state != IDLE));
    if (advance) begin
      if (scan == LAST_SCAN) begin
        scan_next = 4'd0;
        row_next  = text_row + 6'd1;
      end else begin
        scan_next = scan + 4'd1;
      end
    end
    start     = line_start && (row_base < ROW_LIMIT) && (row_next < ROW_LIMIT);
    flush     = frame_start || restart;
    push      = pend && !flush;
    // FIFO entries after this edge plus the cell still waiting for its attr byte.
    occupancy = {1'b0, count} - {2'b0, pop} + {2'b0, push} + {2'b0, state == RD_ATTR};
    slot_free = (occupancy < 3'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      text_row  <= '0;
      scan      <= '0;
      col       <= '0;
      pend      <= 1'b0;
      pend_ch   <= '0;
      pend_col  <= '0;
      pend_line <= '0;
      pend_last <= 1'b0;
      // NOTE: the FIFO storage is reset because its head drives the cell outputs directly.
      fifo[0]   <= '0;
      fifo[1]   <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
      ram_ce    <= 1'b0;
      ram_ad    <= '0;
      overrun   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
      text_row <= row_next;
      scan     <= scan_next;

      if (frame_start)  overrun <= 1'b0;
      else if (restart) overrun <= 1'b1;

      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= '0;
      end else begin
        if (push) begin
          fifo[wr_ptr] <= '{ch: pend_ch, attr: ram_dout, col: pend_col,
                            line: pend_line, last: pend_last};
          wr_ptr       <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end

      pend   <= 1'b0;
      ram_ce <= 1'b0;

      if (start) begin
        state  <= RD_CHAR;
        col    <= '0;
        ram_ce <= 1'b1;
        ram_ad <= {row_next[4:0], 6'd0};
      end else if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          RD_CHAR: begin
            state  <= RD_ATTR;
            ram_ce <= 1'b1;
            ram_ad <= {ram_ad[10:1], 1'b1};
          end
          RD_ATTR: begin
            pend      <= 1'b1;
            pend_ch   <= ram_dout;
            pend_col  <= col;
            pend_line <= scan;
            pend_last <= (col == LAST_COL);
            if (col == LAST_COL) begin
              state <= DRAIN;
            end else if (slot_free) begin
              state  <= RD_CHAR;
              col    <= next_col;
              ram_ce <= 1'b1;
              ram_ad <= {text_row[4:0], next_col, 1'b0};
            end else begin
              state <= WAIT;
            end
          end
          WAIT: begin
            if (slot_free) begin
              state  <= RD_CHAR;
              col    <= next_col;
              ram_ce <= 1'b1;
              ram_ad <= {text_row[4:0], next_col, 1'b0};
            end
          end
          DRAIN:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
